// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
package stream_demux_pkg;

   // Width of the optional out-of-range drop counter.
   localparam int unsigned DROP_CNT_W = 16;

   // LSB position of channel k inside a flattened N*w data bus.
   function automatic int unsigned chan_lsb(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One output slot: a data register plus a FULL/EMPTY valid bit.
// Load wins over drain, so a simultaneous drain+load keeps the slot full with the new beat.
module stream_demux_slot #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              drain,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              valid_d, valid_q;
   logic [DATA_W-1:0] data_d, data_q;

   // Next-state: load has priority, drain empties, data is kept on drain.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   // Slot state register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-channel back-pressure.
// Optional feature: define STREAM_DEMUX_DROP_CNT_EN to add a saturating drop_cnt output
// counting accepted beats whose in_sel is out of range.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int unsigned N_OUT  = 4,
   parameter int unsigned DATA_W = 8,
   localparam int unsigned SEL_W = $clog2(N_OUT)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [SEL_W-1:0]        in_sel,
   output logic [N_OUT-1:0]        out_valid,
   input  logic [N_OUT-1:0]        out_ready,
   output logic [N_OUT*DATA_W-1:0] out_data
`ifdef STREAM_DEMUX_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0]   drop_cnt
`endif
);

   logic             sel_in_range;
   logic             accept;
   logic [N_OUT-1:0] load;

   assign sel_in_range = (32'(in_sel) < N_OUT);
   assign accept       = in_valid & in_ready;

   // Ready when the addressed slot is empty or draining; out-of-range beats are always taken.
   always_comb begin
      in_ready = 1'b0;
      if (!rst_n) begin
         in_ready = 1'b0;
      end else if (sel_in_range) begin
         in_ready = ~out_valid[in_sel] | out_ready[in_sel];
      end else begin
         in_ready = 1'b1;
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_slot
      localparam int unsigned Lsb = chan_lsb(k, DATA_W);

      assign load[k] = accept & (in_sel == SEL_W'(k));

      stream_demux_slot #(
         .DATA_W (DATA_W)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[k]),
         .drain     (out_ready[k]),
         .load_data (in_data),
         .valid     (out_valid[k]),
         .data      (out_data[Lsb +: DATA_W])
      );
   end

`ifdef STREAM_DEMUX_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_d, drop_cnt_q;

   // Count discarded beats, saturating at all-ones.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (accept && !sel_in_range && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   // Drop counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   // Out-of-range beats are accepted and silently discarded with no bookkeeping.
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux (N_OUT=4 and N_OUT=5 instances).
module tb_stream_demux;

   logic clk = 1'b0;
   logic rst_n;

   // N_OUT=4 instance signals
   logic        in_valid4;
   logic        in_ready4;
   logic [7:0]  in_data4;
   logic [1:0]  in_sel4;
   logic [3:0]  out_valid4;
   logic [3:0]  out_ready4;
   logic [31:0] out_data4;

   // N_OUT=5 instance signals
   logic        in_valid5;
   logic        in_ready5;
   logic [7:0]  in_data5;
   logic [2:0]  in_sel5;
   logic [4:0]  out_valid5;
   logic [4:0]  out_ready5;
   logic [39:0] out_data5;

`ifdef STREAM_DEMUX_DROP_CNT_EN
   logic [15:0] drop4;
   logic [15:0] drop5;
`endif

   int total = 0;
   int fails = 0;

   always #5 clk = ~clk;

   stream_demux #(
      .N_OUT  (4),
      .DATA_W (8)
   ) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .in_data   (in_data4),
      .in_sel    (in_sel4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_data  (out_data4)
`ifdef STREAM_DEMUX_DROP_CNT_EN
      ,
      .drop_cnt  (drop4)
`endif
   );

   stream_demux #(
      .N_OUT  (5),
      .DATA_W (8)
   ) u_dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid5),
      .in_ready  (in_ready5),
      .in_data   (in_data5),
      .in_sel    (in_sel5),
      .out_valid (out_valid5),
      .out_ready (out_ready5),
      .out_data  (out_data5)
`ifdef STREAM_DEMUX_DROP_CNT_EN
      ,
      .drop_cnt  (drop5)
`endif
   );

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one active edge and move just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid4  = 1'b0;
      in_data4   = '0;
      in_sel4    = '0;
      out_ready4 = '0;
      in_valid5  = 1'b0;
      in_data5   = '0;
      in_sel5    = '0;
      out_ready5 = '0;

      // Reset state
      #3;
      chk("rst_in_ready", 40'(in_ready4), 40'h0);
      chk("rst_out_valid", 40'(out_valid4), 40'h0);
      chk("rst_out_data", 40'(out_data4), 40'h0);
      chk("rst_out_valid5", 40'(out_valid5), 40'h0);
      tick();
      tick();
      rst_n = 1'b1;

      // Single beat to channel 2 with all consumers ready
      out_ready4 = 4'hF;
      in_valid4  = 1'b1;
      in_data4   = 8'hA5;
      in_sel4    = 2'd2;
      #1;
      chk("s1_in_ready", 40'(in_ready4), 40'h1);
      tick();
      in_valid4 = 1'b0;
      chk("s1_valid", 40'(out_valid4), 40'h4);
      chk("s1_data2", 40'(out_data4[23:16]), 40'hA5);
      tick();
      chk("s1_valid_gone", 40'(out_valid4), 40'h0);
      chk("s1_data_kept", 40'(out_data4[23:16]), 40'hA5);

      // Channel 1 stalled: second beat waits, then drain+load with no bubble
      out_ready4 = 4'b1101;
      in_valid4  = 1'b1;
      in_sel4    = 2'd1;
      in_data4   = 8'h11;
      tick();
      in_data4 = 8'h22;
      #1;
      chk("s2_in_ready_blocked", 40'(in_ready4), 40'h0);
      tick();
      chk("s2_valid_hold", 40'(out_valid4), 40'h2);
      chk("s2_data_hold", 40'(out_data4[15:8]), 40'h11);
      out_ready4 = 4'hF;
      #1;
      chk("s2_in_ready_drain", 40'(in_ready4), 40'h1);
      tick();
      in_valid4 = 1'b0;
      chk("s2_valid_nobubble", 40'(out_valid4), 40'h2);
      chk("s2_data_new", 40'(out_data4[15:8]), 40'h22);
      tick();
      chk("s2_valid_drained", 40'(out_valid4), 40'h0);

      // Channel 0 full and stalled; channel 3 still flows every cycle
      out_ready4 = 4'b1110;
      in_valid4  = 1'b1;
      in_sel4    = 2'd0;
      in_data4   = 8'h5A;
      tick();
      for (int i = 0; i < 4; i++) begin
         in_sel4  = 2'd3;
         in_data4 = 8'(8'h30 + i);
         #1;
         chk("s3_in_ready", 40'(in_ready4), 40'h1);
         tick();
         chk("s3_data3", 40'(out_data4[31:24]), 40'(8'h30 + i));
         chk("s3_data0", 40'(out_data4[7:0]), 40'h5A);
         chk("s3_valid", 40'(out_valid4), 40'h9);
      end
      in_valid4  = 1'b0;
      out_ready4 = 4'hF;
      tick();
      chk("s3_drained", 40'(out_valid4), 40'h0);

      // Round-robin stream 0x00..0x0F at full rate
      for (int i = 0; i < 16; i++) begin
         in_valid4 = 1'b1;
         in_sel4   = 2'(i % 4);
         in_data4  = 8'(i);
         #1;
         chk("s4_in_ready", 40'(in_ready4), 40'h1);
         tick();
         chk("s4_valid", 40'(out_valid4), 40'(1 << (i % 4)));
         chk("s4_data", 40'(out_data4[(i % 4) * 8 +: 8]), 40'(i));
      end
      in_valid4 = 1'b0;
      tick();
      chk("s4_idle", 40'(out_valid4), 40'h0);

      // N_OUT=5: out-of-range beats discarded, then one beat to channel 4
      out_ready5 = 5'h1F;
      in_valid5  = 1'b1;
      in_sel5    = 3'd6;
      for (int i = 0; i < 3; i++) begin
         in_data5 = 8'(8'hD0 + i);
         #1;
         chk("s5_in_ready_drop", 40'(in_ready5), 40'h1);
         tick();
         chk("s5_no_valid", 40'(out_valid5), 40'h0);
      end
      in_sel5  = 3'd4;
      in_data5 = 8'h44;
      #1;
      chk("s5_in_ready4", 40'(in_ready5), 40'h1);
      tick();
      in_valid5 = 1'b0;
      chk("s5_valid4", 40'(out_valid5), 40'h10);
      chk("s5_data4", 40'(out_data5[39:32]), 40'h44);
`ifdef STREAM_DEMUX_DROP_CNT_EN
      chk("s5_drop3", 40'(drop5), 40'h3);
      in_valid5 = 1'b1;
      in_sel5   = 3'd7;
      for (int i = 0; i < 65531; i++) tick();
      in_valid5 = 1'b0;
      chk("s5_drop_fffe", 40'(drop5), 40'hFFFE);
      in_valid5 = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      in_valid5 = 1'b0;
      chk("s5_drop_sat", 40'(drop5), 40'hFFFF);
`endif
      tick();

      // Asynchronous reset mid-cycle with slots 0 and 2 full
      out_ready4 = 4'h0;
      in_valid4  = 1'b1;
      in_sel4    = 2'd0;
      in_data4   = 8'hC0;
      tick();
      in_sel4  = 2'd2;
      in_data4 = 8'hC2;
      tick();
      in_sel4 = 2'd1;
      chk("s6_full", 40'(out_valid4), 40'h5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s6_valid_cleared", 40'(out_valid4), 40'h0);
      chk("s6_in_ready_low", 40'(in_ready4), 40'h0);
      chk("s6_data_cleared", 40'(out_data4), 40'h0);
      in_valid4 = 1'b0;
      tick();
      rst_n = 1'b1;

      // First beat after reset behaves like the first scenario
      out_ready4 = 4'hF;
      in_valid4  = 1'b1;
      in_data4   = 8'hA5;
      in_sel4    = 2'd2;
      #1;
      chk("s6_in_ready", 40'(in_ready4), 40'h1);
      tick();
      in_valid4 = 1'b0;
      chk("s6_valid", 40'(out_valid4), 40'h4);
      chk("s6_data2", 40'(out_data4[23:16]), 40'hA5);
      tick();
      chk("s6_valid_gone", 40'(out_valid4), 40'h0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered, parametrised 1-to-N stream demultiplexer with valid/ready flow control. It routes each accepted input beat to the output channel chosen by `in_sel`, holding it in a per-channel register slot until that channel's consumer takes it. Independent back-pressure per channel lets a stalled consumer block only traffic addressed to it. It is the clocked, handshaked successor to the combinational 1-to-4 demux and sits between a single producer and N downstream consumers.

## Interface
- `N_OUT`, default 4: number of output channels, ≥2, need not be a power of two.
- `DATA_W`, default 8: payload width in bits, ≥1.
- `SEL_W` (localparam): `$clog2(N_OUT)`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: producer has a beat.
- `in_ready` output 1: block can accept the beat.
- `in_data` input DATA_W: payload.
- `in_sel` input SEL_W: destination channel index.
- `out_valid` output N_OUT: bit k set means slot k holds a beat.
- `out_ready` input N_OUT: bit k set means consumer k takes the beat.
- `out_data` output N_OUT*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
- `drop_cnt` output 16: drop counter; present only with `STREAM_DEMUX_DROP_CNT_EN`.

## Operation
- A beat is accepted when `in_valid & in_ready` is true.
- `in_ready` is combinational:
  - When `in_sel < N_OUT`: `in_ready = ~out_valid[in_sel] | out_ready[in_sel]`.
  - When `in_sel ≥ N_OUT`: `in_ready = 1`. The beat is accepted and discarded. No slot changes.
  - `in_ready = 0` while `rst_n` is low.
- Slot k update, in priority order:
  - Accept with `in_sel == k`: `out_valid[k] <= 1`, `out_data[k] <= in_data`.
  - Else, if `out_ready[k]`: `out_valid[k] <= 0`.
  - Else: hold.
  - Data is not cleared on drain.
- If slot k drains and reloads in the same cycle, the slot ends with the new beat and `out_valid[k]` stays 1. No bubble.
- Slots are independent. Draining slot j has no effect on slot k.
- Protocol obligations:
  - Producer: once `in_valid` is high, hold `in_data`/`in_sel` stable until accepted.
  - Block: once `out_valid[k]` is high, hold `out_data[k]` stable until `out_ready[k]`.
- No combinational path from `in_data` to `out_data`.
- There is no state machine beyond the per-slot valid bit (EMPTY/FULL):
  - EMPTY→FULL on load.
  - FULL→EMPTY on `out_ready` with no load.
  - FULL→FULL on load+drain.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `drop_cnt` = 0. `in_ready` is forced to 0 during reset.
- Reset asserted mid-operation discards all held beats immediately, without waiting for a clock edge.
- Latency: a beat accepted at edge n is visible on `out_valid[k]`/`out_data[k]` after edge n.
- Throughput: one beat per cycle into any channel whose consumer holds `out_ready` high.
- Combinational path from `out_ready[in_sel]` and `in_sel` to `in_ready`: depth is one mux plus one OR.

## Configuration
- `STREAM_DEMUX_DROP_CNT_EN` defined:
  - `drop_cnt` port exists.
  - Increments by 1 on each accepted beat with `in_sel ≥ N_OUT`.
  - Saturates at 16'hFFFF.
  - Resets to 0.
- `STREAM_DEMUX_DROP_CNT_EN` undefined: no port and no counter logic. Out-of-range beats are still accepted and discarded.

## Structure
- Shared package `stream_demux_pkg`: `DROP_CNT_W = 16` constant, and a helper function for slicing flattened channel data.
- Sub-module `stream_demux_slot`: one DATA_W register plus valid bit with `load`/`drain` inputs. Instantiated N_OUT times in a generate loop.
- Top level holds the `in_ready` mux, per-slot load decode, and the optional drop counter.

## Test plan
- Reset, then N_OUT=4, DATA_W=8: send `in_data`=8'hA5 with `in_sel`=2 and all `out_ready`=1 → `out_valid`=4'b0100 for exactly one cycle, `out_data[2]`=8'hA5; all other `out_valid` bits stay 0.
- `out_ready[1]`=0: send 8'h11 then 8'h22 to channel 1 → first beat accepted; `in_ready`=0 while second is pending; `out_data[1]` holds 8'h11. Raise `out_ready[1]` → 8'h22 is accepted that cycle and appears next cycle with no gap in `out_valid[1]`.
- Channel 0 stalled (`out_ready[0]`=0, slot full): beats sent to channel 3 → accepted every cycle, and slot 0 data is unchanged.
- Continuous stream 8'h00..8'h0F round-robin over channels 0..3 with all ready → 16 beats delivered in 16 cycles, each on the matching channel in order.
- N_OUT=5 with macro defined: send 3 beats with `in_sel`=6, then 1 beat with `in_sel`=4 → `in_ready`=1 throughout, `drop_cnt`=3, and only `out_valid[4]` asserts. Preload `drop_cnt` to 16'hFFFE and send 3 drops → `drop_cnt` saturates at 16'hFFFF.
- Assert `rst_n` low asynchronously while slots 0 and 2 are full → `out_valid`=0 and `in_ready`=0 immediately. After release, the first beat behaves as in the first scenario.
